// File: rtl/irq_log_pkg.sv
// Shared types and helpers for the interrupt event logger.
// Severity codes, FSM states and log-entry width.
package irq_log_pkg;

    localparam logic [1:0] SEV_WARN  = 2'b01;
    localparam logic [1:0] SEV_EMERG = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // {sev, ts, accel, steer, brake}
    function automatic int entry_width(input int ts_w);
        return 2 + ts_w + 24;
    endfunction

endpackage

// File: rtl/irq_log_fifo.sv
// Synchronous FIFO with registered read data and registered status.
// Pointers carry an extra wrap bit; a pop frees room for a same-edge push.
module irq_log_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/irq_event_logger.sv
// Logs monitor interrupts with timestamp and sensor snapshot into a FIFO.
// One-cycle ack per logged event; drops on full are counted.
module irq_event_logger
    import irq_log_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TS_W        = 16,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     irq,
    input  logic [7:0]                     accel,
    input  logic [7:0]                     steer,
    input  logic [7:0]                     brake,
    output logic                           irq_ack,
    input  logic                           rd_en,
    output logic [entry_width(TS_W)-1:0]   rd_data,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH):0]         count,
    output logic [7:0]                     drop_cnt,
    input  logic                           drop_clr
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    state_t          state;
    logic [TS_W-1:0] ts;
    logic [TW-1:0]   timer;
    logic [1:0]      sev;
    logic [1:0]      log_sev;
    logic            log_evt;
    logic            timeout;
    logic            drop;

    assign sev     = irq[1] ? SEV_EMERG : (irq[0] ? SEV_WARN : 2'b00);
    assign timeout = (timer == TW'(ACK_TIMEOUT - 1));
    assign irq_ack = (state == ACK);
    assign drop    = log_evt && full && !(rd_en && !empty);

    // Only an upgrade from warning to emergency re-logs while released
    always_comb begin
        log_evt = 1'b0;
        unique case (state)
            IDLE:    log_evt = |irq;
            RELEASE: log_evt = irq[1] && (log_sev == SEV_WARN);
            default: log_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ts      <= '0;
            timer   <= '0;
            log_sev <= 2'b00;
        end else begin
            ts <= ts + 1'b1;
            if (log_evt)
                log_sev <= sev;
            unique case (state)
                IDLE: begin
                    if (log_evt)
                        state <= ACK;
                end
                ACK: begin
                    state <= RELEASE;
                    timer <= '0;
                end
                RELEASE: begin
                    if (irq == 2'b00)
                        state <= IDLE;
                    else if (log_evt)
                        state <= ACK;
                    else if (timeout)
                        state <= IDLE;
                    else
                        timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt <= '0;
        else if (drop_clr)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;
    end

    irq_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (entry_width(TS_W))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (log_evt),
        .wr_data  ({sev, ts, accel, steer, brake}),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

endmodule

// File: tb/tb_irq_event_logger.sv
// Bench for irq_event_logger: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_irq_event_logger;

    localparam int DEPTH = 8;
    localparam int TS_W  = 4;
    localparam int TO    = 16;
    localparam int EW    = 2 + TS_W + 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    irq = 2'b00;
    logic [7:0]    accel = 8'h00;
    logic [7:0]    steer = 8'h00;
    logic [7:0]    brake = 8'h00;
    logic          rd_en = 1'b0;
    logic          drop_clr = 1'b0;
    logic          irq_ack;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [EW-1:0] rd_data;
    logic [3:0]    count;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    irq_event_logger #(
        .DEPTH       (DEPTH),
        .TS_W        (TS_W),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .accel    (accel),
        .steer    (steer),
        .brake    (brake),
        .irq_ack  (irq_ack),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .drop_cnt (drop_cnt),
        .drop_clr (drop_clr)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // behavioural model: engaged = an event was logged and irq not yet released
    logic [EW-1:0] q[$];
    int            ts_m = 0;
    int            drop_m = 0;
    int            edge_no = 0;
    int            log_edge = 0;
    int            age = 0;
    bit            engaged = 0;
    logic [1:0]    log_sev = 2'b00;
    logic [1:0]    m_sev;
    bit            m_log;
    bit            m_pop;
    bit            m_full;
    bit            exp_ack = 0;
    bit            exp_rv = 0;
    logic [EW-1:0] exp_rd = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            ts_m = 0; drop_m = 0; edge_no = 0; log_edge = 0;
            engaged = 0; log_sev = 2'b00;
            exp_ack = 0; exp_rv = 0; exp_rd = '0;
        end else begin
            m_sev = irq[1] ? 2'b10 : (irq[0] ? 2'b01 : 2'b00);
            m_log = 0;
            if (!engaged) begin
                m_log = (irq != 2'b00);
            end else begin
                age = edge_no - log_edge;
                if (age >= 2) begin
                    if (irq == 2'b00)
                        engaged = 0;
                    else if (irq[1] && log_sev == 2'b01)
                        m_log = 1;
                    else if (age == 1 + TO)
                        engaged = 0;
                end
            end
            m_full = (q.size() == DEPTH);
            m_pop  = rd_en && (q.size() != 0);
            exp_rv = m_pop;
            if (m_pop)
                exp_rd = q.pop_front();
            if (m_log) begin
                if (!m_full || m_pop)
                    q.push_back({m_sev, TS_W'(ts_m), accel, steer, brake});
                else if (drop_m < 255)
                    drop_m++;
                engaged  = 1;
                log_edge = edge_no;
                log_sev  = m_sev;
            end
            if (drop_clr)
                drop_m = 0;
            exp_ack = m_log;
            ts_m = (ts_m + 1) % (1 << TS_W);
            edge_no++;
        end
    end

    bit chk_on = 0;
    int ack_seen = 0;

    always @(negedge clk) begin
        if (rst && chk_on) begin
            chk("irq_ack", irq_ack, exp_ack);
            chk("rd_valid", rd_valid, exp_rv);
            chk("rd_data", rd_data, exp_rd);
            chk("count", count, q.size());
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == DEPTH);
            chk("drop_cnt", drop_cnt, drop_m);
            if (irq_ack)
                ack_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [EW-1:0] e_lit;
    logic [3:0]    t0, t1, t2;
    int            a0;

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_ack", irq_ack, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        chk_on = 1;
        cyc(2);

        // warning path: logged at the 3rd edge after release, ts = 2
        irq = 2'b01; accel = 8'hFB; steer = 8'h14; brake = 8'h00;
        cyc(1); chk("warn_ack_hi", irq_ack, 1);
        cyc(1); chk("warn_ack_lo", irq_ack, 0);
        cyc(1); irq = 2'b00;
        cyc(2); chk("warn_count", count, 1);
        rd_en = 1'b1; cyc(1); rd_en = 1'b0;
        e_lit = {2'b01, 4'd2, 8'hFB, 8'h14, 8'h00};
        chk("warn_valid", rd_valid, 1);
        chk("warn_entry", rd_data, e_lit);
        cyc(1);

        // escalation
        irq = 2'b01;
        cyc(1); chk("esc_ack1", irq_ack, 1);
        cyc(1); chk("esc_gap", irq_ack, 0); irq = 2'b10;
        cyc(1); chk("esc_ack2", irq_ack, 1);
        cyc(2); irq = 2'b00;
        cyc(3); chk("esc_count", count, 2);
        rd_en = 1'b1;
        cyc(1); chk("esc_sev1", rd_data[EW-1 -: 2], 2'b01);
        cyc(1); chk("esc_sev2", rd_data[EW-1 -: 2], 2'b10);
        rd_en = 1'b0;
        cyc(1);

        // overflow
        a0 = ack_seen;
        for (int i = 0; i < 10; i++) begin
            irq = 2'b01; accel = 8'(i);
            cyc(1); irq = 2'b00;
            cyc(2);
        end
        cyc(1);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 8);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_acks", ack_seen - a0, 10);
        drop_clr = 1'b1; cyc(1); drop_clr = 1'b0;
        chk("drop_clr", drop_cnt, 0);

        // full with simultaneous push and pop
        irq = 2'b01; rd_en = 1'b1; accel = 8'h77;
        cyc(1); irq = 2'b00; rd_en = 1'b0;
        chk("pp_valid", rd_valid, 1);
        chk("pp_oldest", rd_data[23:16], 8'h00);
        chk("pp_count", count, 8);
        chk("pp_drop", drop_cnt, 0);
        cyc(2);
        rd_en = 1'b1; cyc(8); rd_en = 1'b0;
        chk("pp_newest", rd_data[23:16], 8'h77);
        cyc(1); chk("drain_empty", empty, 1);

        // timeout re-log and timestamp wrap
        irq = 2'b10; cyc(40); irq = 2'b00;
        cyc(3); chk("to_count", count, 3);
        rd_en = 1'b1;
        cyc(1); t0 = rd_data[27:24];
        cyc(1); t1 = rd_data[27:24];
        cyc(1); t2 = rd_data[27:24];
        cyc(1); chk("rd_on_empty", rd_valid, 0);
        rd_en = 1'b0;
        chk("to_dt1", 4'(t1 - t0), 4'd2);
        chk("to_dt2", 4'(t2 - t1), 4'd2);
        cyc(1);

        // reset mid-operation
        for (int i = 0; i < 2; i++) begin
            irq = 2'b01; cyc(1); irq = 2'b00; cyc(2);
        end
        irq = 2'b01; cyc(3);
        chk("pre_rst_count", count, 3);
        #2 rst = 1'b0;
        #1;
        chk("mrst_ack", irq_ack, 0);
        chk("mrst_data", rd_data, 0);
        chk("mrst_valid", rd_valid, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_full", full, 0);
        chk("mrst_count", count, 0);
        chk("mrst_drop", drop_cnt, 0);
        @(negedge clk);
        irq = 2'b00; rst = 1'b1;
        cyc(2);

        // random traffic
        repeat (500) begin
            if ($urandom_range(0, 3) == 0)
                irq = 2'($urandom);
            rd_en    = ($urandom_range(0, 3) == 0);
            drop_clr = ($urandom_range(0, 40) == 0);
            accel = 8'($urandom);
            steer = 8'($urandom);
            brake = 8'($urandom);
            cyc(1);
        end
        irq = 2'b00; rd_en = 1'b0; drop_clr = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_event_logger.md
# irq_event_logger

Downstream consumer of the driver monitor's interrupt output. It detects each warning/emergency interrupt and snapshots the severity, a free-running timestamp and the concurrent accel/steer/brake sample into a FIFO. It returns a one-cycle `irq_ack` to the monitor. The host drains the log through a registered read port; dropped events are counted.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of 2, ≥2
- `TS_W`, 16: timestamp width
- `ACK_TIMEOUT`, 16: cycles in RELEASE before a still-asserted irq re-arms

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `irq`  in  2  from monitor: 01 warning, 10 emergency, 11 treated as emergency
- `accel`  in  8  signed sample, captured with event
- `steer`  in  8  signed sample, captured with event
- `brake`  in  8  unsigned sample, captured with event
- `irq_ack`  out  1  one-cycle acknowledge to monitor
- `rd_en`  in  1  host pop request
- `rd_data`  out  2+TS_W+24  {sev[1:0], ts, accel, steer, brake}
- `rd_valid`  out  1  `rd_data` valid, one-cycle pulse
- `empty`  out  1  FIFO empty
- `full`  out  1  FIFO full
- `count`  out  $clog2(DEPTH)+1  occupancy
- `drop_cnt`  out  8  events lost on full; saturates at 255
- `drop_clr`  in  1  synchronous clear of `drop_cnt`

## Operation
- Timestamp counter:
  - Increments every cycle from 0.
  - Wraps 2^TS_W−1 → 0 with no flag.
- Severity encoding: `sev` = 2'b10 if `irq[1]`, else 2'b01 if `irq[0]`. Emergency wins on 11.
- FSM states:
  - IDLE: `irq`≠0 at an edge → log event, go ACK.
  - ACK: `irq_ack`=1; unconditionally go RELEASE next edge.
  - RELEASE:
    - `irq`=0 → IDLE.
    - Escalation: `irq[1]` rises while the logged sev was warning → log new emergency event, go ACK.
    - Timeout: timer reaches ACK_TIMEOUT with `irq`≠0 → IDLE. A new event is logged on the following edge.
- Log event:
  - Push {sev, ts, accel, steer, brake}, all sampled at the same edge.
  - If FIFO full and no pop that edge: entry dropped, `drop_cnt`+1 (saturating). Ack still issued.
- Read:
  - `rd_en` with !`empty` pops the head. `rd_data` and `rd_valid` are registered from that edge.
  - `rd_en` on empty is ignored: no pulse, no pointer change.
  - `rd_data` holds its last value when not popping.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - When full, the push succeeds because the pop frees the slot.
- `drop_clr` and a drop increment in the same edge → clear wins (result 0).

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - outputs: `irq_ack`=0, `rd_data`=0, `rd_valid`=0, `empty`=1, `full`=0, `count`=0, `drop_cnt`=0
  - internal: ts=0, state IDLE, pointers 0
- Reset mid-operation discards all entries. Release is synchronous to `clk` by the user.
- Event sampled at edge N:
  - Entry written at N; `count`/`empty` update after N.
  - `irq_ack` high for the cycle between N and N+1, driven from a flop, never combinational from `irq`.
- Minimum spacing between logged events: 2 cycles (ACK always lasts one cycle).
- Escalation during ACK is not seen until RELEASE, so the earliest re-log is N+2.
- Read latency: `rd_en` at edge M → `rd_valid`/`rd_data` valid after M for one cycle. Back-to-back pops are allowed every cycle.
- `count`, `empty` and `full` are registered and consistent with each other every cycle.

## Structure
- Package `irq_log_pkg` holds:
  - severity codes SEV_WARN=2'b01, SEV_EMERG=2'b10
  - FSM state enum {IDLE, ACK, RELEASE}
  - entry-width function of TS_W
- Sub-module `irq_log_fifo`: synchronous FIFO with DEPTH and WIDTH parameters.
  - Pointers carry an extra wrap bit.
  - Registered read data.
  - Outputs: `full`, `empty`, `count`.
- Top holds the FSM, timestamp counter, RELEASE timer and drop counter.

## Test plan
- Warning path: reset, `irq`=01 for 3 cycles with accel=−5, steer=20, brake=0, then 00.
  - One entry {01, ts, 0xFB, 0x14, 0x00}.
  - `irq_ack` high exactly one cycle, one edge after detection.
  - `count`=1.
- Escalation: `irq`=01, then 10 two cycles later and held.
  - Two entries, sev 01 then 10.
  - Two `irq_ack` pulses 2 cycles apart.
- Overflow: DEPTH=8, issue 10 separate warnings with no reads.
  - `full`=1, `count`=8, `drop_cnt`=2, every event acked.
  - `drop_clr` → `drop_cnt`=0.
- Full plus simultaneous push/pop: with FIFO full, assert `rd_en` on the edge a new event arrives.
  - Oldest entry returned with `rd_valid` pulse.
  - New entry stored; `count` stays 8; `drop_cnt` unchanged.
- Timeout and wrap: hold `irq`=10 for 40 cycles with ACK_TIMEOUT=16, TS_W=4.
  - Re-logged roughly every 18 cycles, 3 entries total.
  - Timestamps wrap modulo 16.
  - `rd_en` on empty after draining produces no `rd_valid`.
- Reset mid-operation: assert `rst`=0 with 3 entries queued and FSM in RELEASE.
  - All outputs reach reset values immediately without a clock edge.
